// File: rtl/microwave_cook_controller_if.sv
// Signal bundle between the keypad/timer input stage, the cook controller,
// and the display/magnetron drivers. Clock and reset stay outside the bundle.
// The master side drives the keypad, timer, and button inputs. The slave
// side is the controller.
interface microwave_cook_controller_if;
  logic [3:0] digit;
  logic       key_valid;
  logic       tick_1hz;
  logic       startn;
  logic       stopn;
  logic       door_closed;
  logic       keypad_enablen;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       mag_on;
  logic       done;
  logic [1:0] state;

  modport master (
    output digit, key_valid, tick_1hz, startn, stopn, door_closed,
    input  keypad_enablen, min_ones, sec_tens, sec_ones, mag_on, done, state
  );

  modport slave (
    input  digit, key_valid, tick_1hz, startn, stopn, door_closed,
    output keypad_enablen, min_ones, sec_tens, sec_ones, mag_on, done, state
  );
endinterface

// File: rtl/microwave_cook_controller.sv
// Microwave cook sequencing controller.
// - Builds an M:SS cook time from keypad digits.
// - Counts the time down in BCD on 1 Hz tick edges while the magnetron is on.
// - Handles door interlock, start, and stop/pause.
// - Drives a completion beep lasting BEEP_CYCLES clocks.
// Optional feature: define COOK_CTRL_ADD30_EN to enable start-adds-30-seconds.
// With the feature, a start at 0:00 loads 0:30, and a start while cooking adds 30 s,
// saturating at 9:59.
module microwave_cook_controller #(
  parameter int unsigned BEEP_CYCLES = 300
) (
  input  logic                        clk,
  input  logic                        resetn,
  microwave_cook_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned CNT_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [3:0]       min_q, min_d, tens_q, tens_d, ones_q, ones_d;
  logic [CNT_W-1:0] beep_q, beep_d;
  logic             key_q, tick_q, startn_q, stopn_q;
  logic             mag_q, done_q;

  logic key_edge, tick_edge, start_edge, stop_edge, time_zero;
  logic [3:0] dec_min, dec_tens, dec_ones;

  assign key_edge   = bus.key_valid & ~key_q;
  assign tick_edge  = bus.tick_1hz & ~tick_q;
  assign start_edge = ~bus.startn & startn_q;
  assign stop_edge  = ~bus.stopn & stopn_q;
  assign time_zero  = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

  // One-second BCD decrement; tens wraps 0->5 so that M:SS borrows a minute.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    dec_min  = min_q;
    dec_tens = tens_q;
    dec_ones = ones_q - 4'd1;
    if (ones_q == 4'd0) begin
      dec_ones = 4'd9;
      if (tens_q == 4'd0) begin
        dec_tens = 4'd5;
        dec_min  = min_q - 4'd1;
      end else begin
        dec_tens = tens_q - 4'd1;
      end
    end
  end

`ifdef COOK_CTRL_ADD30_EN
  logic [4:0] add_t, add_m;
  logic [3:0] add_min, add_tens, add_ones;

  // Add 30 s. Entered tens up to 9 may need two minute carries. Clamp at 9:59.
  always_comb begin
    add_t = {1'b0, tens_q} + 5'd3;
    add_m = {1'b0, min_q};
    if (add_t >= 5'd6) begin
      add_t = add_t - 5'd6;
      add_m = add_m + 5'd1;
    end
    if (add_t >= 5'd6) begin
      add_t = add_t - 5'd6;
      add_m = add_m + 5'd1;
    end
    if (add_m > 5'd9) begin
      add_min  = 4'd9;
      add_tens = 4'd5;
      add_ones = 4'd9;
    end else begin
      add_min  = add_m[3:0];
      add_tens = add_t[3:0];
      add_ones = ones_q;
    end
  end
`endif

  // Next-state and next-digit logic; priority is stop > door > start > tick > key.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    beep_d  = '0;
    case (state_q)
      IDLE: begin
        if (stop_edge) begin
          min_d  = 4'd0;
          tens_d = 4'd0;
          ones_d = 4'd0;
        end else if (start_edge && bus.door_closed && !time_zero) begin
          state_d = COOK;
`ifdef COOK_CTRL_ADD30_EN
        end else if (start_edge && bus.door_closed) begin
          state_d = COOK;
          tens_d  = 4'd3;
`endif
        end else if (key_edge && (bus.digit <= 4'd9)) begin
          min_d  = tens_q;
          tens_d = ones_q;
          ones_d = bus.digit;
        end
      end
      COOK: begin
        if (stop_edge || !bus.door_closed) begin
          state_d = PAUSE;
`ifdef COOK_CTRL_ADD30_EN
        end else if (start_edge) begin
          min_d  = add_min;
          tens_d = add_tens;
          ones_d = add_ones;
`endif
        end else if (tick_edge) begin
          min_d  = dec_min;
          tens_d = dec_tens;
          ones_d = dec_ones;
          if ((dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0)) begin
            state_d = DONE;
          end
        end
      end
      PAUSE: begin
        if (stop_edge) begin
          state_d = IDLE;
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
        end else if (start_edge && bus.door_closed) begin
          state_d = COOK;
        end
      end
      default: begin
        // DONE: the digits already read 0:00, so an abort needs no clear.
        if (stop_edge || key_edge) begin
          state_d = IDLE;
        end else if (beep_q == CNT_W'(BEEP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          beep_d = beep_q + CNT_W'(1);
        end
      end
    endcase
  end

  // State, digits, edge-detect copies, and registered output decodes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      min_q    <= 4'd0;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      beep_q   <= '0;
      key_q    <= 1'b0;
      tick_q   <= 1'b0;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
      mag_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      min_q    <= min_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      beep_q   <= beep_d;
      key_q    <= bus.key_valid;
      tick_q   <= bus.tick_1hz;
      startn_q <= bus.startn;
      stopn_q  <= bus.stopn;
      mag_q    <= (state_d == COOK);
      done_q   <= (state_d == DONE);
    end
  end

  assign bus.state          = state_q;
  assign bus.min_ones       = min_q;
  assign bus.sec_tens       = tens_q;
  assign bus.sec_ones       = ones_q;
  assign bus.mag_on         = mag_q;
  assign bus.done           = done_q;
  assign bus.keypad_enablen = (state_q == IDLE) || (state_q == COOK);

endmodule

// File: doc/microwave_cook_controller.md
# microwave_cook_controller

Sequencing controller for the microwave timer. Consumes the keypad digit/valid pair and the 1 Hz tick produced by the timer input stage, builds a three-digit M:SS cook time from key presses, and counts it down while the magnetron is enabled. Handles door interlock, start, and stop/pause, and drives a timed completion beep. Sits between the keypad/timer input stage and the display and magnetron drivers.

## Interface
- BEEP_CYCLES, default 300: clk cycles `done` stays high (3 s at 100 Hz).
- clk  input  1  system clock (100 Hz nominal); all state on posedge.
- resetn  input  1  asynchronous active-low reset.
- digit  input  4  BCD key digit from the priority encoder; values above 9 are ignored.
- key_valid  input  1  high while a key is held; the rising edge is one keypress.
- tick_1hz  input  1  1 Hz square wave; the rising edge is one second.
- startn  input  1  start button, active low; the falling edge is a press.
- stopn  input  1  stop/clear button, active low; the falling edge is a press.
- door_closed  input  1  1 = door shut.
- keypad_enablen  output  1  1 = keypad and tick path enabled (IDLE and COOK).
- min_ones  output  4  minutes digit, BCD.
- sec_tens  output  4  tens-of-seconds digit, BCD.
- sec_ones  output  4  seconds digit, BCD.
- mag_on  output  1  magnetron enable.
- done  output  1  completion beep.
- state  output  2  IDLE=0, COOK=1, PAUSE=2, DONE=3.

## Operation
- Edge detection uses registered copies of the inputs: key_q, tick_q, startn_q, stopn_q. Edge = current input value versus the registered copy, sampled at the same posedge. All inputs are synchronous to clk.
- **IDLE**
  - Valid key edge shifts the digits: min_ones←sec_tens, sec_tens←sec_ones, sec_ones←digit.
  - Stop edge clears all digits to 0.
  - Start edge with door_closed=1 and time≠0:00 → COOK.
- **COOK**
  - mag_on=1.
  - Each tick edge decrements the time in BCD:
    - sec_ones 0→9 with borrow.
    - sec_tens 0→5 with borrow into min_ones.
    - Entered values such as 0:90 are counted down as entered (0:90→0:89).
  - When the time reaches 0:00 after a decrement → DONE.
  - door_closed=0 → PAUSE.
  - Stop edge → PAUSE.
- **PAUSE**
  - mag_on=0; time is held.
  - Start edge with door_closed=1 → COOK.
  - Stop edge → IDLE with digits cleared.
- **DONE**
  - done=1 and the time shows 0:00.
  - After BEEP_CYCLES cycles → IDLE.
  - A stop edge or key edge aborts to IDLE at once; the key is not loaded.
- **Priority within one cycle:** stop > door open > start > tick > key.
  - No decrement occurs in a cycle where COOK is exited for another reason.
  - A start edge together with a stop edge does nothing except the stop action.
- Key edges outside IDLE (other than the DONE abort) are ignored.
- keypad_enablen=1 in IDLE and COOK, 0 in PAUSE and DONE.

## Timing
- Reset values:
  - state=IDLE.
  - All digits 0.
  - mag_on=0, done=0, keypad_enablen=1.
  - key_q=0, tick_q=0, startn_q=1, stopn_q=1.
  - Beep counter 0.
- Latency: an input edge first sampled at posedge k updates state and digits at posedge k. Outputs are registered and visible after edge k.
- mag_on is a registered decode of the next state. It rises at the same edge where state becomes COOK and falls at the edge leaving COOK.
- done is high for exactly BEEP_CYCLES cycles unless aborted.
- Door open during COOK drops mag_on at the first posedge where door_closed=0 is sampled.
- A held key produces one shift; a held start produces one start.
- Asserting resetn mid-COOK forces all reset values immediately (asynchronous).

## Configuration
- COOK_CTRL_ADD30_EN defined:
  - Start edge in IDLE with time 0:00 and door closed loads 0:30 and enters COOK.
  - Start edge in COOK adds 30 s in BCD, saturating at 9:59.
- Undefined:
  - Start with time 0:00 is ignored.
  - Start in COOK is ignored.

## Test plan
- Keys 1,3,0, door closed, start → display 1:30, state=COOK, mag_on=1. After 90 tick edges: 0:00, done=1 for 300 cycles, then IDLE.
- Time 1:00 in COOK, one tick edge → 0:59. Entered 0:90, one tick → 0:89.
- COOK at 0:45, door opens → mag_on=0 the next posedge, state=PAUSE, time held. Close door and press start → COOK resumes from 0:45. Stop edge in PAUSE → IDLE, 0:00.
- Start edge and stop edge in the same cycle in IDLE at 0:20 → digits cleared, stays IDLE. Tick and stop in the same cycle in COOK → PAUSE, no decrement.
- Reset asserted in COOK at 0:12 → all outputs at reset values immediately. Digit 12 with a key edge in IDLE → no shift.
- With COOK_CTRL_ADD30_EN defined: start at 0:00 → 0:30 and COOK. Start at 9:45 → 9:59.
